uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
UART transmitter for the v65C02 UART controller, complementing the existing receiver. It is preset for 8-N-1 with an optional second stop bit, and is paced by the shared baud-rate-generator strobe (16 strobes per bit). A one-byte transmit holding register (THR) feeds a transmit shift register (TSR), so the CPU can queue the next byte while the current one shifts out. Consecutive bytes go out back-to-back, with no idle gap.

Parameters:
OVERSAMPLE, 16, brg_stb_i pulses per serial bit; legal range 2..16; counter width 4 bits.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk_i  input  1  CPU clock; the only clock in the block.
rst_i  input  1  synchronous, active-high reset.
brg_stb_i  input  1  baud-rate-generator strobe; single-cycle pulse at 16x baud.
din_i  input  8  parallel byte to transmit; sampled when wr_stb_i=1.
wr_stb_i  input  1  single-cycle write strobe into the THR.
dout_o  output  1  serial line; idle high; driven from a register.
thr_empty_o  output  1  1 = THR can accept a write.
tx_busy_o  output  1  1 = a frame is on the line (start, data or stop bit).
done_stb_o  output  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (rst_i=1 at a clk_i edge) has priority over everything else. Next-cycle values:
  - dout_o=1, thr_empty_o=1, tx_busy_o=0, done_stb_o=0.
  - State=S_IDLE; baud, bit and stop counters cleared.
  - THR contents discarded.
  - A frame in progress is aborted immediately, and no done_stb_o is produced.
- THR write:
  - If wr_stb_i=1 and thr_empty_o=1, THR<=din_i and thr_empty_o<=0.
  - If wr_stb_i=1 and thr_empty_o=0, the write is ignored and the THR contents are unchanged (no overwrite).
- States: S_IDLE, S_START, S_DATA, S_STOP.
- S_IDLE:
  - dout_o=1.
  - If the THR is full: TSR<=THR, THR marked empty (thr_empty_o=1 on the next cycle), baud counter<=0, state<=S_START.
  - dout_o goes low on the cycle after the load.
  - A wr_stb_i arriving in the same cycle as this load is ignored, because thr_empty_o is still 0.
- Bit timing (all non-idle states):
  - The baud counter increments on each brg_stb_i.
  - A bit period ends on the cycle where brg_stb_i=1 and the counter equals OVERSAMPLE-1; the counter then wraps to 0.
  - No strobe is counted on the load cycle itself. Wall-clock bit length is therefore exactly OVERSAMPLE strobe intervals, measured from the first counted strobe.
- S_START: dout_o=0. At the end of the bit period: dout_o<=TSR[0], bit counter<=0, state<=S_DATA.
- S_DATA:
  - Data is sent LSB first.
  - At the end of each bit period, TSR shifts right.
  - If bit counter=7: state<=S_STOP, dout_o<=1. Otherwise the bit counter increments and dout_o<=next bit.
- S_STOP:
  - dout_o=1 for STOP_BITS bit periods.
  - At the end of the last period: done_stb_o=1 for exactly one cycle (registered, on the following cycle).
  - If the THR is full at that edge: TSR<=THR, THR emptied, state<=S_START, so dout_o falls immediately with no idle cycle.
  - Otherwise: state<=S_IDLE.
- tx_busy_o=1 in S_START, S_DATA and S_STOP; 0 in S_IDLE. It stays 1 continuously across back-to-back frames.
- A write accepted during a frame is held in the THR until the frame's final stop-bit edge.
- brg_stb_i outside a frame has no effect; the baud counter is held at 0 in S_IDLE.
- Frame length: (1 + 8 + STOP_BITS) x OVERSAMPLE strobes.

Test Plan:
1. Reset, then brg_stb_i every 4 clocks; write 0xA5.
   -> Line sequence 0,1,0,1,0,0,1,0,1,1 with each bit 64 clocks long.
   -> thr_empty_o back to 1 two cycles after the write.
   -> One done_stb_o pulse; tx_busy_o=0 afterwards.
2. Write 0x55; while it is in S_DATA, write 0x0F.
   -> thr_empty_o=0 until the 0x55 stop bit ends.
   -> 0x0F start bit begins on the cycle right after that stop bit, with no high gap.
   -> Two done_stb_o pulses; tx_busy_o held at 1 throughout.
3. Write 0x11, then write 0x22 and 0x33 while the THR is still full.
   -> 0x33 is dropped.
   -> Frames 0x11 then 0x22 appear on the line; exactly two done_stb_o pulses.
4. Write 0xFF; assert rst_i in the middle of data bit 3.
   -> dout_o=1 on the next cycle; thr_empty_o=1; tx_busy_o=0; no done_stb_o.
   -> A subsequent write of 0x00 sends a clean frame.
5. Set STOP_BITS=2, OVERSAMPLE=8; write 0x80.
   -> Start bit, then data 0,0,0,0,0,0,0,1, then a high level for 16 strobes before done_stb_o.
6. Write 0x3C with no brg_stb_i pulses.
   -> dout_o stays 0 (start bit) indefinitely and tx_busy_o=1.
   -> Resuming the strobes completes the frame correctly.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered 8-N-1 UART transmitter, paced by the shared baud strobe.
// One-byte holding register feeds the shift register for gapless frames.
module uart_tx_buffered #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       brg_stb_i,
  input  logic [7:0] din_i,
  input  logic       wr_stb_i,
  output logic       dout_o,
  output logic       thr_empty_o,
  output logic       tx_busy_o,
  output logic       done_stb_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  localparam logic [3:0] BAUD_LAST = 4'(OVERSAMPLE - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  state_e     state_q, state_d;
  logic [3:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic       stop_q, stop_d;
  logic [7:0] tsr_q, tsr_d;
  logic [7:0] thr_q, thr_d;
  logic       full_q, full_d;
  logic       dout_q, dout_d;
  logic       done_q, done_d;
  logic       bit_end;

  assign bit_end = brg_stb_i && (baud_q == BAUD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      tsr_q   <= '0;
      thr_q   <= '0;
      full_q  <= 1'b0;
      dout_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      tsr_q   <= tsr_d;
      thr_q   <= thr_d;
      full_q  <= full_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    tsr_d   = tsr_q;
    thr_d   = thr_q;
    full_d  = full_q;
    dout_d  = dout_q;
    done_d  = 1'b0;

    // a write while the THR is full is dropped
    if (wr_stb_i && !full_q) begin
      thr_d  = din_i;
      full_d = 1'b1;
    end

    if (state_q != S_IDLE && brg_stb_i) begin
      baud_d = bit_end ? 4'd0 : baud_q + 4'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        dout_d = 1'b1;
        baud_d = '0;
        if (full_q) begin
          tsr_d   = thr_q;
          full_d  = 1'b0;
          dout_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          dout_d  = tsr_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          tsr_d = {1'b0, tsr_q[7:1]};
          if (bit_q == 3'd7) begin
            dout_d  = 1'b1;
            stop_d  = 1'b0;
            state_d = S_STOP;
          end else begin
            bit_d  = bit_q + 3'd1;
            dout_d = tsr_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            done_d = 1'b1;
            // reload straight from the THR so the next start bit has no gap
            if (full_q) begin
              tsr_d   = thr_q;
              full_d  = 1'b0;
              dout_d  = 1'b0;
              baud_d  = '0;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dout_o      = dout_q;
  assign thr_empty_o = !full_q;
  assign tx_busy_o   = (state_q != S_IDLE);
  assign done_stb_o  = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a strobe-counting line monitor
// decodes frames and compares them with bytes queued at write time.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       brg = 1'b0;
  logic       brg_en = 1'b0;
  logic [7:0] din = '0;
  logic       wr_a = 1'b0;
  logic       wr_b = 1'b0;
  logic       dout_a, empty_a, busy_a, done_a;
  logic       dout_b, empty_b, busy_b, done_b;

  int total = 0;
  int bad = 0;
  int nd_a = 0;
  int nd_b = 0;
  int ph = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  uart_tx_buffered #(.OVERSAMPLE(16), .STOP_BITS(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .brg_stb_i(brg), .din_i(din),
    .wr_stb_i(wr_a), .dout_o(dout_a), .thr_empty_o(empty_a),
    .tx_busy_o(busy_a), .done_stb_o(done_a)
  );

  uart_tx_buffered #(.OVERSAMPLE(8), .STOP_BITS(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .brg_stb_i(brg), .din_i(din),
    .wr_stb_i(wr_b), .dout_o(dout_b), .thr_empty_o(empty_b),
    .tx_busy_o(busy_b), .done_stb_o(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // strobe every 4th clock while enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      brg = brg_en && (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done_a === 1'b1) nd_a++;
      if (done_b === 1'b1) nd_b++;
    end
  end

  task automatic monitor(input int d);
    int os, sb, cnt, k;
    logic [7:0] data, exp;
    logic line, fin, aborted;
    os = (d != 0) ? 8 : 16;
    sb = (d != 0) ? 2 : 1;
    @(negedge clk);
    forever begin
      line = (d != 0) ? dout_b : dout_a;
      if (line === 1'b0 && rst === 1'b0) begin
        cnt = 0;
        data = '0;
        fin = 1'b0;
        aborted = 1'b0;
        while (!fin) begin
          if (rst) begin
            aborted = 1'b1;
            fin = 1'b1;
          end else begin
            if (brg) begin
              cnt++;
              if (cnt % os == os / 2) begin
                k = cnt / os;
                line = (d != 0) ? dout_b : dout_a;
                if (k == 0) chk("start_bit", 32'(line), 32'd0);
                else if (k <= 8) data[k-1] = line;
                else chk("stop_bit", 32'(line), 32'd1);
              end
            end
            @(negedge clk);
            if (((d != 0) ? done_b : done_a) === 1'b1) fin = 1'b1;
          end
        end
        if (aborted) begin
          @(negedge clk);
        end else begin
          chk("frame_strobes", 32'(cnt), 32'((9 + sb) * os));
          if (d != 0) begin
            chk("sb_nonempty_b", 32'(q_b.size() > 0), 32'd1);
            if (q_b.size() > 0) begin
              exp = q_b.pop_front();
              chk("byte_b", 32'(data), 32'(exp));
            end
          end else begin
            chk("sb_nonempty_a", 32'(q_a.size() > 0), 32'd1);
            if (q_a.size() > 0) begin
              exp = q_a.pop_front();
              chk("byte_a", 32'(data), 32'(exp));
            end
          end
        end
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic send(input int d, input logic [7:0] b);
    @(posedge clk);
    #1;
    din = b;
    if (d != 0) wr_b = 1'b1;
    else wr_a = 1'b1;
    @(posedge clk);
    #1;
    wr_a = 1'b0;
    wr_b = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int t;
    logic done;
    done = 1'b0;
    t = 0;
    while (!done && t < 4000) begin
      @(negedge clk);
      t++;
      if (d != 0) done = !busy_b && q_b.size() == 0;
      else done = !busy_a && q_a.size() == 0;
    end
    chk("idle_timeout", 32'(done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t, e_err, b_err;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    brg_en = 1'b1;
    @(negedge clk);
    chk("rst_dout", 32'(dout_a), 32'd1);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_dout_b", 32'(dout_b), 32'd1);

    // single frame
    n0 = nd_a;
    q_a.push_back(8'hA5);
    send(0, 8'hA5);
    @(negedge clk);
    chk("t1_empty_lo", 32'(empty_a), 32'd0);
    @(negedge clk);
    chk("t1_empty_hi", 32'(empty_a), 32'd1);
    chk("t1_start", 32'(dout_a), 32'd0);
    chk("t1_busy", 32'(busy_a), 32'd1);
    wait_idle(0);
    chk("t1_ndone", 32'(nd_a - n0), 32'd1);
    chk("t1_busy_end", 32'(busy_a), 32'd0);
    chk("t1_dout_end", 32'(dout_a), 32'd1);

    // back-to-back frames
    n0 = nd_a;
    q_a.push_back(8'h55);
    send(0, 8'h55);
    repeat (200) @(negedge clk);
    q_a.push_back(8'h0F);
    send(0, 8'h0F);
    @(negedge clk);
    chk("t2_thr_full", 32'(empty_a), 32'd0);
    e_err = 0;
    b_err = 0;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 2000) begin
      @(negedge clk);
      t++;
      if (done_a === 1'b1) seen = 1'b1;
      else begin
        if (empty_a !== 1'b0) e_err++;
        if (busy_a !== 1'b1) b_err++;
      end
    end
    chk("t2_done1_seen", 32'(seen), 32'd1);
    chk("t2_gap_dout", 32'(dout_a), 32'd0);
    chk("t2_reload_empty", 32'(empty_a), 32'd1);
    chk("t2_busy_edge", 32'(busy_a), 32'd1);
    seen = 1'b0;
    t = 0;
    while (!seen && t < 2000) begin
      @(negedge clk);
      t++;
      if (done_a === 1'b1) seen = 1'b1;
      else if (busy_a !== 1'b1) b_err++;
    end
    chk("t2_done2_seen", 32'(seen), 32'd1);
    chk("t2_empty_errs", 32'(e_err), 32'd0);
    chk("t2_busy_errs", 32'(b_err), 32'd0);
    wait_idle(0);
    chk("t2_ndone", 32'(nd_a - n0), 32'd2);

    // overwrite of a full THR is dropped
    n0 = nd_a;
    q_a.push_back(8'h11);
    send(0, 8'h11);
    repeat (4) @(negedge clk);
    q_a.push_back(8'h22);
    send(0, 8'h22);
    send(0, 8'h33);
    @(negedge clk);
    chk("t3_thr_full", 32'(empty_a), 32'd0);
    wait_idle(0);
    chk("t3_ndone", 32'(nd_a - n0), 32'd2);

    // reset in the middle of data bit 3
    n0 = nd_a;
    send(0, 8'hFF);
    t = 0;
    while (dout_a !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t4_started", 32'(dout_a), 32'd0);
    repeat (288) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_dout", 32'(dout_a), 32'd1);
    chk("t4_empty", 32'(empty_a), 32'd1);
    chk("t4_busy", 32'(busy_a), 32'd0);
    repeat (100) @(negedge clk);
    chk("t4_no_done", 32'(nd_a - n0), 32'd0);
    chk("t4_idle_line", 32'(dout_a), 32'd1);
    q_a.push_back(8'h00);
    send(0, 8'h00);
    wait_idle(0);
    chk("t4_ndone", 32'(nd_a - n0), 32'd1);

    // two stop bits, 8x oversample
    n0 = nd_b;
    q_b.push_back(8'h80);
    send(1, 8'h80);
    wait_idle(1);
    chk("t5_ndone", 32'(nd_b - n0), 32'd1);
    chk("t5_dout_end", 32'(dout_b), 32'd1);

    // stalled strobes hold the start bit
    n0 = nd_a;
    brg_en = 1'b0;
    repeat (3) @(posedge clk);
    q_a.push_back(8'h3C);
    send(0, 8'h3C);
    repeat (300) @(negedge clk);
    chk("t6_hold_dout", 32'(dout_a), 32'd0);
    chk("t6_hold_busy", 32'(busy_a), 32'd1);
    chk("t6_hold_done", 32'(nd_a - n0), 32'd0);
    brg_en = 1'b1;
    wait_idle(0);
    chk("t6_ndone", 32'(nd_a - n0), 32'd1);
    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
